// File: rtl/i2c_byte_master_if.sv
// Host handshake and SDA/SCL-control signals of the byte-level I2C master.
interface i2c_byte_master_if #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 8
);
    logic              data_clk;
    logic              ena;
    logic [ADDR_W-1:0] addr;
    logic              rw;
    logic [DATA_W-1:0] data_wr;
    logic              sda_in;
    logic              busy;
    logic [DATA_W-1:0] data_rd;
    logic              ack_error;
    logic              sda_oe;
    logic              scl_not_ena;

    modport master (
        input  data_clk, ena, addr, rw, data_wr, sda_in,
        output busy, data_rd, ack_error, sda_oe, scl_not_ena
    );

    modport slave (
        output data_clk, ena, addr, rw, data_wr, sda_in,
        input  busy, data_rd, ack_error, sda_oe, scl_not_ena
    );
endinterface

// File: rtl/i2c_byte_master.sv
// Byte-level I2C master: sequences START, address, data, ACK/NACK, repeated START
// and STOP on SDA, paced by the data_clk phase from the SCL generator.
module i2c_byte_master #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 8
) (
    input logic              clk,
    input logic              rst,
    i2c_byte_master_if.master bus
);
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);
    localparam int unsigned AR_W  = ADDR_W + 1;

    typedef enum logic [3:0] {
        READY, START, COMMAND, SLV_ACK1, WR, RD, SLV_ACK2, MSTR_ACK, STOP
    } state_t;

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] data_rd_q, data_rd_d;
    logic              ack_error_q, ack_error_d;
    logic              sda_oe_q, sda_oe_d;
    logic              scl_not_ena_q, scl_not_ena_d;
    logic              dclk_prev_q;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [AR_W-1:0]   ar_q, ar_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;

    logic              rise, fall, same;
    logic [CNT_W-1:0]  cnt_m1;
    logic [AR_W-1:0]   ar_shift;
    logic [DATA_W-1:0] tx_shift;

    assign rise     = bus.data_clk & ~dclk_prev_q;
    assign fall     = ~bus.data_clk & dclk_prev_q;
    assign same     = ({bus.addr, bus.rw} == ar_q);
    assign cnt_m1   = bit_cnt_q - CNT_W'(1);
    assign ar_shift = ar_q >> cnt_m1;
    assign tx_shift = tx_q >> cnt_m1;

    // Next-state and next-output decode; rise = data change point, fall = SCL-high point
    always_comb begin
        state_d       = state_q;
        busy_d        = busy_q;
        data_rd_d     = data_rd_q;
        ack_error_d   = ack_error_q;
        sda_oe_d      = sda_oe_q;
        scl_not_ena_d = scl_not_ena_q;
        bit_cnt_d     = bit_cnt_q;
        ar_d          = ar_q;
        tx_d          = tx_q;
        rx_d          = rx_q;

        if (rise) begin
            case (state_q)
                READY: begin
                    if (bus.ena) begin
                        ar_d    = {bus.addr, bus.rw};
                        tx_d    = bus.data_wr;
                        busy_d  = 1'b1;
                        state_d = START;
                    end else begin
                        busy_d  = 1'b0;
                    end
                end
                START: begin
                    sda_oe_d  = ~ar_q[ADDR_W];
                    bit_cnt_d = CNT_W'(ADDR_W);
                    state_d   = COMMAND;
                end
                COMMAND: begin
                    if (bit_cnt_q == '0) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = CNT_W'(DATA_W - 1);
                        state_d   = SLV_ACK1;
                    end else begin
                        bit_cnt_d = cnt_m1;
                        sda_oe_d  = ~ar_shift[0];
                    end
                end
                SLV_ACK1: begin
                    if (!ar_q[0]) begin
                        sda_oe_d = ~tx_q[DATA_W-1];
                        state_d  = WR;
                    end else begin
                        sda_oe_d = 1'b0;
                        state_d  = RD;
                    end
                end
                WR: begin
                    if (bit_cnt_q == '0) begin
                        sda_oe_d  = 1'b0;
                        busy_d    = 1'b0;
                        bit_cnt_d = CNT_W'(DATA_W - 1);
                        state_d   = SLV_ACK2;
                    end else begin
                        bit_cnt_d = cnt_m1;
                        sda_oe_d  = ~tx_shift[0];
                    end
                end
                RD: begin
                    if (bit_cnt_q == '0) begin
                        data_rd_d = rx_q;
                        busy_d    = 1'b0;
                        bit_cnt_d = CNT_W'(DATA_W - 1);
                        sda_oe_d  = bus.ena & same;
                        state_d   = MSTR_ACK;
                    end else begin
                        bit_cnt_d = cnt_m1;
                    end
                end
                SLV_ACK2, MSTR_ACK: begin
                    // Same target continues the burst; a new target forces a repeated START
                    if (bus.ena) begin
                        ar_d   = {bus.addr, bus.rw};
                        tx_d   = bus.data_wr;
                        busy_d = 1'b1;
                        if (same && !ar_q[0]) begin
                            sda_oe_d = ~bus.data_wr[DATA_W-1];
                            state_d  = WR;
                        end else if (same) begin
                            sda_oe_d = 1'b0;
                            state_d  = RD;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = START;
                        end
                    end else begin
                        sda_oe_d = 1'b1;
                        state_d  = STOP;
                    end
                end
                default: ;
            endcase
        end else if (fall) begin
            case (state_q)
                START: begin
                    sda_oe_d = 1'b1;
                    if (scl_not_ena_q) ack_error_d = 1'b0;
                    scl_not_ena_d = 1'b0;
                end
                SLV_ACK1, SLV_ACK2: begin
                    if (bus.sda_in) ack_error_d = 1'b1;
                end
                RD: begin
                    rx_d = (rx_q & ~(DATA_W'(1) << bit_cnt_q))
                         | (DATA_W'(bus.sda_in) << bit_cnt_q);
                end
                STOP: begin
                    sda_oe_d      = 1'b0;
                    scl_not_ena_d = 1'b1;
                    busy_d        = 1'b0;
                    state_d       = READY;
                end
                default: ;
            endcase
        end
    end

    // State register; reset releases the bus immediately without a STOP
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= READY;
            busy_q        <= 1'b0;
            data_rd_q     <= '0;
            ack_error_q   <= 1'b0;
            sda_oe_q      <= 1'b0;
            scl_not_ena_q <= 1'b1;
            dclk_prev_q   <= 1'b0;
            bit_cnt_q     <= '0;
            ar_q          <= '0;
            tx_q          <= '0;
            rx_q          <= '0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            data_rd_q     <= data_rd_d;
            ack_error_q   <= ack_error_d;
            sda_oe_q      <= sda_oe_d;
            scl_not_ena_q <= scl_not_ena_d;
            dclk_prev_q   <= bus.data_clk;
            bit_cnt_q     <= bit_cnt_d;
            ar_q          <= ar_d;
            tx_q          <= tx_d;
            rx_q          <= rx_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.data_rd     = data_rd_q;
    assign bus.ack_error   = ack_error_q;
    assign bus.sda_oe      = sda_oe_q;
    assign bus.scl_not_ena = scl_not_ena_q;
endmodule
